lcd_spi_tx: RTL and testbench

//   SPI transmitter that carries LCD command and data bytes to the panel, one byte per handshake.

---
 rtl/lcd_spi_tx_pkg.sv | 13 +
 rtl/lcd_spi_tick.sv | 20 ++
 rtl/lcd_spi_tx.sv | 103 ++++++++++
 tb/tb_lcd_spi_tx.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_spi_tx_pkg.sv
// lcd_spi_tx_pkg: command codes, LCD opcodes and FSM encoding shared by the SPI
// transmitter and the draw controller.
package lcd_spi_tx_pkg;
   localparam logic [1:0] SPI_CMD_COMMAND = 2'b01;
   localparam logic [1:0] SPI_CMD_DATA    = 2'b10;
   localparam logic [7:0] CASET = 8'h2A;
   localparam logic [7:0] RASET = 8'h2B;
   localparam logic [7:0] RAMWR = 8'h2C;
   typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_HOLD} spi_state_t;
   function automatic logic cmd_legal(input logic [1:0] cmd);
      return cmd == SPI_CMD_COMMAND || cmd == SPI_CMD_DATA;
   endfunction
endpackage

// File: rtl/lcd_spi_tick.sv
// lcd_spi_tick: HALF_DIV down-counter giving a one-cycle half-period tick.
// A load restarts the count; the first period after a load is one cycle longer.
module lcd_spi_tick #(
   parameter int HALF_DIV = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic load,
   input  logic en,
   output logic tick
);
   localparam int W = $clog2(HALF_DIV + 1);
   logic [W-1:0] cnt;
   assign tick = en && cnt == '0;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) cnt <= '0;
      else if (load) cnt <= W'(HALF_DIV);
      else if (tick) cnt <= W'(HALF_DIV - 1);
      else if (en) cnt <= cnt - W'(1);
endmodule

// File: rtl/lcd_spi_tx.sv
// lcd_spi_tx: byte-wide SPI mode-0 transmitter for an LCD panel with D/C line,
// per-byte CS framing and a ready/done handshake.
module lcd_spi_tx
   import lcd_spi_tx_pkg::*;
#(
   parameter int HALF_DIV = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       spi_start,
   input  logic [7:0] spi_data,
   input  logic [1:0] spi_cmd,
   output logic       spi_ready,
   output logic       tx_done,
   output logic       cmd_err,
   output logic       lcd_sclk,
   output logic       lcd_mosi,
   output logic       lcd_cs_n,
   output logic       lcd_dc
);
   spi_state_t state, state_nxt;
   logic [6:0] shreg, shreg_nxt;
   logic [3:0] bit_cnt, bit_nxt;
   logic sclk_nxt, mosi_nxt, cs_nxt, dc_nxt, ready_nxt, done_nxt, err_nxt;
   logic load, tick;

   lcd_spi_tick #(.HALF_DIV(HALF_DIV)) u_tick (
      .clk(clk), .reset_n(reset_n), .load(load), .en(state != ST_IDLE), .tick(tick)
   );

   always_comb begin
      state_nxt = state;
      shreg_nxt = shreg;
      bit_nxt = bit_cnt;
      sclk_nxt = lcd_sclk;
      mosi_nxt = lcd_mosi;
      cs_nxt = lcd_cs_n;
      dc_nxt = lcd_dc;
      ready_nxt = spi_ready;
      done_nxt = 1'b0;
      err_nxt = 1'b0;
      load = 1'b0;
      case (state)
         ST_IDLE:
            if (spi_start && cmd_legal(spi_cmd)) begin
               state_nxt = ST_SETUP;
               shreg_nxt = spi_data[6:0];
               mosi_nxt = spi_data[7];
               dc_nxt = spi_cmd[1];
               bit_nxt = '0;
               cs_nxt = 1'b0;
               ready_nxt = 1'b0;
               load = 1'b1;
            end else err_nxt = spi_start;
         ST_SETUP: state_nxt = tick ? ST_SHIFT : ST_SETUP;
         ST_SHIFT:
            if (tick) begin
               sclk_nxt = ~lcd_sclk;
               bit_nxt = bit_cnt + 4'd1;
               // the 16th edge is the last falling edge: no bits left to present
               if (bit_cnt == 4'd15) state_nxt = ST_HOLD;
               else if (lcd_sclk) begin
                  mosi_nxt = shreg[6];
                  shreg_nxt = {shreg[5:0], 1'b0};
               end
            end
         ST_HOLD:
            if (tick) begin
               state_nxt = ST_IDLE;
               cs_nxt = 1'b1;
               mosi_nxt = 1'b0;
               ready_nxt = 1'b1;
               done_nxt = 1'b1;
            end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state <= ST_IDLE;
         shreg <= '0;
         bit_cnt <= '0;
         lcd_sclk <= 1'b0;
         lcd_mosi <= 1'b0;
         lcd_cs_n <= 1'b1;
         lcd_dc <= 1'b0;
         spi_ready <= 1'b1;
         tx_done <= 1'b0;
         cmd_err <= 1'b0;
      end else begin
         state <= state_nxt;
         shreg <= shreg_nxt;
         bit_cnt <= bit_nxt;
         lcd_sclk <= sclk_nxt;
         lcd_mosi <= mosi_nxt;
         lcd_cs_n <= cs_nxt;
         lcd_dc <= dc_nxt;
         spi_ready <= ready_nxt;
         tx_done <= done_nxt;
         cmd_err <= err_nxt;
      end
endmodule

// File: tb/tb_lcd_spi_tx.sv
// tb_lcd_spi_tx: drives a HALF_DIV=2 and a HALF_DIV=1 transmitter and checks them
// against a panel-side slave model and a byte scoreboard.
module tb_lcd_spi_tx;
   import lcd_spi_tx_pkg::*;
   logic clk = 1'b0, reset_n = 1'b0;
   logic start2 = 1'b0, start1 = 1'b0;
   logic [7:0] data2 = '0, data1 = '0;
   logic [1:0] cmd2 = '0, cmd1 = '0;
   logic ready2, done2, err2, sclk2, mosi2, cs2, dc2;
   logic ready1, done1, err1, sclk1, mosi1, cs1, dc1;
   int total = 0, bad = 0;

   always #5 clk = ~clk;

   lcd_spi_tx #(.HALF_DIV(2)) dut2 (
      .clk(clk), .reset_n(reset_n), .spi_start(start2), .spi_data(data2), .spi_cmd(cmd2),
      .spi_ready(ready2), .tx_done(done2), .cmd_err(err2), .lcd_sclk(sclk2),
      .lcd_mosi(mosi2), .lcd_cs_n(cs2), .lcd_dc(dc2)
   );
   lcd_spi_tx #(.HALF_DIV(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .spi_start(start1), .spi_data(data1), .spi_cmd(cmd1),
      .spi_ready(ready1), .tx_done(done1), .cmd_err(err1), .lcd_sclk(sclk1),
      .lcd_mosi(mosi1), .lcd_cs_n(cs1), .lcd_dc(dc1)
   );

   // panel-side slave: frame = cs_n low interval; bits sampled on sclk rise;
   // per frame records the byte, the rise count and which dc levels were seen
   logic [7:0] sh2 = '0, sh1 = '0;
   int rc2 = 0, rc1 = 0;
   logic [1:0] dcs2 = '0, dcs1 = '0;
   logic pcs2 = 1'b1, psc2 = 1'b0, pcs1 = 1'b1, psc1 = 1'b0;
   logic [7:0] qb2[$], qb1[$];
   int qr2[$], qr1[$];
   logic [1:0] qd2[$], qd1[$];

   always @(negedge clk) begin
      if (pcs2 && cs2 === 1'b0) begin sh2 = '0; rc2 = 0; dcs2 = '0; end
      if (cs2 === 1'b0 && sclk2 && !psc2) begin
         sh2 = {sh2[6:0], mosi2}; rc2++; dcs2[dc2] = 1'b1;
      end
      if (!pcs2 && cs2 === 1'b1) begin qb2.push_back(sh2); qr2.push_back(rc2); qd2.push_back(dcs2); end
      pcs2 = (cs2 !== 1'b0); psc2 = sclk2;
      if (pcs1 && cs1 === 1'b0) begin sh1 = '0; rc1 = 0; dcs1 = '0; end
      if (cs1 === 1'b0 && sclk1 && !psc1) begin
         sh1 = {sh1[6:0], mosi1}; rc1++; dcs1[dc1] = 1'b1;
      end
      if (!pcs1 && cs1 === 1'b1) begin qb1.push_back(sh1); qr1.push_back(rc1); qd1.push_back(dcs1); end
      pcs1 = (cs1 !== 1'b0); psc1 = sclk1;
   end

   task automatic wait_ready2(output int n);
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!ready2 && n < 200);
   endtask

   task automatic wait_ready1(output int n);
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!ready1 && n < 200);
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      total++;
      if ({ready2, done2, err2, sclk2, mosi2, cs2, dc2} !== 7'b1000010) begin
         bad++; $display("FAIL reset2 got=%b want=1000010", {ready2, done2, err2, sclk2, mosi2, cs2, dc2});
      end
      total++;
      if ({ready1, done1, err1, sclk1, mosi1, cs1, dc1} !== 7'b1000010) begin
         bad++; $display("FAIL reset1 got=%b want=1000010", {ready1, done1, err1, sclk1, mosi1, cs1, dc1});
      end
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_frame2(input logic [7:0] d, input logic [1:0] c);
      int n, base;
      base = qb2.size();
      @(negedge clk); start2 = 1'b1; data2 = d; cmd2 = c;
      @(posedge clk); #1;
      total++;
      if ({cs2, dc2, ready2} !== {1'b0, c[1], 1'b0}) begin
         bad++; $display("FAIL accept cs/dc/ready got=%b want=%b", {cs2, dc2, ready2}, {1'b0, c[1], 1'b0});
      end
      @(negedge clk); start2 = 1'b0;
      wait_ready2(n);
      total++;
      if (n !== 37) begin bad++; $display("FAIL latency2 got=%0d want=37", n); end
      total++;
      if ({done2, cs2, mosi2, dc2} !== {1'b1, 1'b1, 1'b0, c[1]}) begin
         bad++; $display("FAIL end done/cs/mosi/dc got=%b want=%b", {done2, cs2, mosi2, dc2}, {3'b110, c[1]});
      end
      @(posedge clk); #1;
      total++;
      if (done2 !== 1'b0) begin bad++; $display("FAIL done_pulse got=%b want=0", done2); end
      @(negedge clk);
      total++;
      if (qb2.size() != base + 1) begin
         bad++; $display("FAIL frame_count got=%0d want=%0d", qb2.size() - base, 1);
      end else begin
         total++;
         if ({qb2[base], qd2[base]} !== {d, c[1] ? 2'b10 : 2'b01} || qr2[base] != 8) begin
            bad++; $display("FAIL slave byte=%h dcs=%b rises=%0d want byte=%h dc=%b rises=8",
                            qb2[base], qd2[base], qr2[base], d, c[1]);
         end
      end
   endtask

   task automatic test_cmd;
      test_frame2(CASET, SPI_CMD_COMMAND);
   endtask

   task automatic test_data;
      test_frame2(8'hA5, SPI_CMD_DATA);
   endtask

   task automatic test_illegal;
      logic [1:0] ills[2] = '{2'b11, 2'b00};
      int base;
      base = qb2.size();
      foreach (ills[i]) begin
         @(negedge clk); start2 = 1'b1; cmd2 = ills[i]; data2 = RASET;
         @(posedge clk); #1;
         total++;
         if ({err2, cs2, ready2} !== 3'b111) begin
            bad++; $display("FAIL illegal_%b err/cs/ready got=%b want=111", ills[i], {err2, cs2, ready2});
         end
         @(negedge clk); start2 = 1'b0;
         @(posedge clk); #1;
         total++;
         if ({err2, cs2, ready2} !== 3'b011) begin
            bad++; $display("FAIL illegal_after err/cs/ready got=%b want=011", {err2, cs2, ready2});
         end
      end
      repeat (40) @(negedge clk);
      total++;
      if (qb2.size() != base) begin bad++; $display("FAIL illegal_frames got=%0d want=0", qb2.size() - base); end
   endtask

   task automatic test_back_to_back;
      int n, base;
      base = qb2.size();
      @(negedge clk); start2 = 1'b1; data2 = RAMWR; cmd2 = SPI_CMD_COMMAND;
      @(posedge clk);
      @(negedge clk); data2 = 8'hFF; cmd2 = SPI_CMD_DATA;
      wait_ready2(n);
      total++;
      if (n !== 37 || cs2 !== 1'b1) begin bad++; $display("FAIL b2b_first lat=%0d cs=%b want 37/1", n, cs2); end
      @(posedge clk); #1;
      total++;
      if ({cs2, ready2, dc2} !== 3'b001) begin
         bad++; $display("FAIL b2b_restart cs/ready/dc got=%b want=001", {cs2, ready2, dc2});
      end
      @(negedge clk); start2 = 1'b0;
      wait_ready2(n);
      total++;
      if (n !== 37) begin bad++; $display("FAIL b2b_second lat got=%0d want=37", n); end
      repeat (2) @(negedge clk);
      total++;
      if (qb2.size() != base + 2) begin
         bad++; $display("FAIL b2b_frames got=%0d want=2", qb2.size() - base);
      end else begin
         total++;
         if ({qb2[base], qd2[base], qb2[base+1], qd2[base+1]} !== {RAMWR, 2'b01, 8'hFF, 2'b10}) begin
            bad++; $display("FAIL b2b_bytes got=%h/%b %h/%b want=2c/01 ff/10",
                            qb2[base], qd2[base], qb2[base+1], qd2[base+1]);
         end
      end
   endtask

   task automatic test_mid_reset;
      int nd = 0;
      @(negedge clk); start2 = 1'b1; data2 = 8'h55; cmd2 = SPI_CMD_DATA;
      @(posedge clk);
      @(negedge clk); start2 = 1'b0;
      repeat (15) @(posedge clk);
      @(negedge clk); reset_n = 1'b0; #1;
      total++;
      if ({cs2, sclk2, ready2, mosi2, done2, dc2} !== 6'b101000) begin
         bad++; $display("FAIL midreset cs/sclk/ready/mosi/done/dc got=%b want=101000",
                         {cs2, sclk2, ready2, mosi2, done2, dc2});
      end
      @(negedge clk); reset_n = 1'b1;
      repeat (60) begin @(posedge clk); #1; if (done2) nd++; end
      total++;
      if (nd != 0 || ready2 !== 1'b1) begin bad++; $display("FAIL midreset_after dones=%0d ready=%b want 0/1", nd, ready2); end
   endtask

   task automatic test_sweep;
      logic [7:0] eb[$];
      logic [1:0] ed[$];
      logic [7:0] d;
      logic [1:0] c;
      int n, base;
      base = qb1.size();
      for (int i = 0; i < 64; i++) begin
         d = 8'($urandom);
         c = 2'($urandom_range(1, 2));
         eb.push_back(d);
         ed.push_back(c == SPI_CMD_DATA ? 2'b10 : 2'b01);
         @(negedge clk); start1 = 1'b1; data1 = d; cmd1 = c;
         @(posedge clk);
         @(negedge clk); start1 = 1'b0; data1 = 8'($urandom); cmd1 = 2'($urandom);
         wait_ready1(n);
         total++;
         if (n !== 19) begin bad++; $display("FAIL sweep_lat[%0d] got=%0d want=19", i, n); end
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end
      repeat (2) @(negedge clk);
      total++;
      if (qb1.size() != base + 64) begin
         bad++; $display("FAIL sweep_frames got=%0d want=64", qb1.size() - base);
      end else begin
         for (int i = 0; i < 64; i++) begin
            total++;
            if ({qb1[base+i], qd1[base+i]} !== {eb[i], ed[i]} || qr1[base+i] != 8) begin
               bad++; $display("FAIL sweep[%0d] byte=%h dcs=%b rises=%0d want byte=%h dcs=%b rises=8",
                               i, qb1[base+i], qd1[base+i], qr1[base+i], eb[i], ed[i]);
            end
         end
      end
   endtask

   initial begin
      test_reset;
      test_cmd;
      test_data;
      test_illegal;
      test_back_to_back;
      test_mid_reset;
      test_sweep;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
